// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and by the receive stage
// (receiver_timing_and_shift_register).
//   - uart_state_e : state encodings common to both ends of the link
//   - WLS_*        : word-length select codes
//   - word_mask()  : mask of the data bits actually present for a WLS code
//   - parity_expect(): expected parity bit for a word under PEN/EPS/SP rules
//   - rx_dbg_t     : receiver debug view (FSM state and latched frame config)
// Optional feature macro used elsewhere in this slice: RX_BREAK_DETECT_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    RESET      = 3'b000,
    IDLE       = 3'b010,
    START_BIT  = 3'b011,
    DATA_BITS  = 3'b100,
    PARITY_BIT = 3'b101,
    STOP_BIT   = 3'b110
  } uart_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef struct packed {
    uart_state_e state;
    logic [2:0]  bit_idx;
    logic        pen;
    logic        eps;
    logic        sp;
    logic        stb;
    logic [1:0]  wls;
  } rx_dbg_t;

  function automatic logic [7:0] word_mask(input logic [1:0] wls);
    logic [7:0] m;
    case (wls)
      WLS_5:   m = 8'h1F;
      WLS_6:   m = 8'h3F;
      WLS_7:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Expected parity bit. EPS=1 selects even parity (bit makes the total
  // count of ones even); stick parity forces the bit to ~EPS.
  function automatic logic parity_expect(input logic [7:0] data,
                                         input logic [1:0] wls,
                                         input logic       eps,
                                         input logic       sp);
    logic [7:0] w;
    w = data & word_mask(wls);
    if (sp) return ~eps;
    return eps ? ^w : ~^w;
  endfunction

endpackage

// File: rtl/receiver_timing_and_shift_register_if.sv
// Bus between the UART receive stage and its environment.
//   master : drives the serial line and line control, consumes the results
//   slave  : the receiver
// Signals: rx, PEN, EPS, SP, STB, WLS (line side); data_out, valid, busy,
// parity_error, framing_error and, with RX_BREAK_DETECT_EN, break_detect.
//
// Handshake: valid is a one-cycle strobe with no back-pressure (there is no
// ready). data_out, parity_error, framing_error (and break_detect) are only
// meaningful in the cycle valid=1; the consumer must take them that cycle.
// data_out alone holds its value until the next valid.
interface receiver_timing_and_shift_register_if;
  logic       rx;
  logic       PEN;
  logic       EPS;
  logic       SP;
  logic       STB;
  logic [1:0] WLS;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       parity_error;
  logic       framing_error;
`ifdef RX_BREAK_DETECT_EN
  logic       break_detect;
`endif

  modport master (
    output rx, PEN, EPS, SP, STB, WLS,
    input  data_out, valid, busy, parity_error, framing_error
`ifdef RX_BREAK_DETECT_EN
    , break_detect
`endif
  );

  modport slave (
    input  rx, PEN, EPS, SP, STB, WLS,
    output data_out, valid, busy, parity_error, framing_error
`ifdef RX_BREAK_DETECT_EN
    , break_detect
`endif
  );
endinterface

// File: rtl/receiver_timing_and_shift_register_sample_tick.sv
// rx_sample_tick: front end of the UART receiver.
//   - optional synchronizer (SYNC_STAGES flops, 0 = use rx directly)
//   - line history flop and falling-edge detect (history updated every clock)
//   - oversampling tick counter: tick when cnt==OSR-1, mid when cnt==OSR/2-1
// Ports:
//   m_clk, reset  : clock, synchronous active-high reset
//   rx_i          : raw serial line
//   cnt_clr_i     : restart the tick counter at 0 next cycle
//   rx_s_o        : line value as seen by the FSM
//   fall_o        : previous sample 1, current sample 0
//   tick_o, mid_o : bit-sample point and start-bit mid point
module rx_sample_tick #(
  parameter int OSR         = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic m_clk,
  input  logic reset,
  input  logic rx_i,
  input  logic cnt_clr_i,
  output logic rx_s_o,
  output logic fall_o,
  output logic tick_o,
  output logic mid_o
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic [CW-1:0] MID  = (OSR > 1) ? CW'(OSR / 2 - 1) : '0;

  logic          hist_q;
  logic [CW-1:0] cnt_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s_o = rx_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Line idles high, so the chain resets to 1 to avoid a false edge.
      always_ff @(posedge m_clk) begin
        if (reset) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= rx_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign rx_s_o = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge m_clk) begin
    if (reset) begin
      hist_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      hist_q <= rx_s_o;
      if (cnt_clr_i || cnt_q == LAST) cnt_q <= '0;
      else                            cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fall_o = hist_q & ~rx_s_o;
  // With OSR=1 the counter is pinned at 0, so every cycle is a tick.
  assign tick_o = (cnt_q == LAST);
  assign mid_o  = (cnt_q == MID);

endmodule

// File: rtl/receiver_timing_and_shift_register.sv
// receiver_timing_and_shift_register: UART receive stage.
// Detects a start bit, shifts in 5-8 data bits LSB first, checks optional
// parity and the first stop bit, and reports the word with a one-cycle valid.
// Parameters: OSR (1, 4, 8, 16 clocks per bit), SYNC_STAGES (0 or 2).
// Ports:
//   m_clk, reset : clock, synchronous active-high reset
//   bus          : receiver_timing_and_shift_register_if.slave
//   dbg_o        : FSM state, bit index and latched frame configuration
// Optional feature: RX_BREAK_DETECT_EN adds bus.break_detect, pulsed with
// valid when data, parity (if enabled) and stop bit were all 0.
module receiver_timing_and_shift_register
  import uart_pkg::*;
#(
  parameter int OSR         = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic                                 m_clk,
  input  logic                                 reset,
  receiver_timing_and_shift_register_if.slave  bus,
  output rx_dbg_t                              dbg_o
);

  logic rx_s, fall, tick, mid, cnt_clr;

  rx_sample_tick #(.OSR(OSR), .SYNC_STAGES(SYNC_STAGES)) u_tick (
    .m_clk     (m_clk),
    .reset     (reset),
    .rx_i      (bus.rx),
    .cnt_clr_i (cnt_clr),
    .rx_s_o    (rx_s),
    .fall_o    (fall),
    .tick_o    (tick),
    .mid_o     (mid)
  );

  uart_state_e state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        pen_q, pen_d, eps_q, eps_d, sp_q, sp_d, stb_q, stb_d;
  logic [1:0]  wls_q, wls_d;
  logic        par_err_q, par_err_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
`ifdef RX_BREAK_DETECT_EN
  logic        par_bit_q, par_bit_d;
  logic        brk_q, brk_d;
`endif

  always_ff @(posedge m_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      stb_q      <= 1'b0;
      wls_q      <= '0;
      par_err_q  <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      par_bit_q  <= 1'b0;
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      pen_q      <= pen_d;
      eps_q      <= eps_d;
      sp_q       <= sp_d;
      stb_q      <= stb_d;
      wls_q      <= wls_d;
      par_err_q  <= par_err_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef RX_BREAK_DETECT_EN
      par_bit_q  <= par_bit_d;
      brk_q      <= brk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pen_d      = pen_q;
    eps_d      = eps_q;
    sp_d       = sp_q;
    stb_d      = stb_q;
    wls_d      = wls_q;
    par_err_d  = par_err_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    cnt_clr    = 1'b0;
`ifdef RX_BREAK_DETECT_EN
    par_bit_d  = par_bit_q;
    brk_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Edge-triggered: a line stuck low cannot start a second frame.
        if (fall) begin
          pen_d     = bus.PEN;
          eps_d     = bus.EPS;
          sp_d      = bus.SP;
          stb_d     = bus.STB;
          wls_d     = bus.WLS;
          busy_d    = 1'b1;
          shift_d   = '0;
          bit_idx_d = '0;
          par_err_d = 1'b0;
          cnt_clr   = 1'b1;
          // Without oversampling the edge sample itself is the start bit.
          state_d   = (OSR == 1) ? DATA_BITS : START_BIT;
        end
      end

      START_BIT: begin
        if (mid) begin
          if (!rx_s) begin
            cnt_clr = 1'b1;
            state_d = DATA_BITS;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      DATA_BITS: begin
        if (tick) begin
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          // Last data index is WLS+4, i.e. {1, WLS}.
          if (bit_idx_q == {1'b1, wls_q}) state_d = pen_q ? PARITY_BIT : STOP_BIT;
        end
      end

      PARITY_BIT: begin
        if (tick) begin
          par_err_d = rx_s ^ parity_expect(shift_q, wls_q, eps_q, sp_q);
`ifdef RX_BREAK_DETECT_EN
          par_bit_d = rx_s;
`endif
          state_d   = STOP_BIT;
        end
      end

      STOP_BIT: begin
        if (tick) begin
          ferr_d     = ~rx_s;
          perr_d     = par_err_q;
          data_out_d = shift_q;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
`ifdef RX_BREAK_DETECT_EN
          brk_d      = ~rx_s & (shift_q == 8'h00) & ~(pen_q & par_bit_q);
`endif
          state_d    = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_out      = data_out_q;
  assign bus.valid         = valid_q;
  assign bus.busy          = busy_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;
`ifdef RX_BREAK_DETECT_EN
  assign bus.break_detect  = brk_q;
`endif

  assign dbg_o = '{state: state_q, bit_idx: bit_idx_q, pen: pen_q, eps: eps_q,
                   sp: sp_q, stb: stb_q, wls: wls_q};

endmodule

// File: doc/receiver_timing_and_shift_register.md
Name: receiver_timing_and_shift_register

Overview:
Serial-to-parallel UART receive stage, the downstream consumer of the transmitter's `tx` line.
- Detects the start bit, shifts in 5–8 data bits LSB-first, and checks optional parity and the stop bit.
- Presents the word with a one-cycle `valid` pulse plus error flags.
- Uses the same line-control inputs (PEN, EPS, SP, WLS, STB) as the transmitter, so loopback pairing is direct.

Parameters:
- OSR, 1: clock ticks per bit. Legal values are 1, 4, 8, 16. At 1 the block samples one bit per m_clk, matching the transmitter.
- SYNC_STAGES, 0: flops on `rx` before use. Use 0 when the same clock domain drives `rx`, 2 when `rx` is asynchronous.

Ports:
- m_clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- rx  in  1  serial line; idles high
- PEN  in  1  parity enable
- EPS  in  1  even parity select (1 = even, 0 = odd)
- SP  in  1  stick parity (expected bit = ~EPS)
- STB  in  1  stop-bit select; only the first stop bit is checked
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- data_out  out  8  received word; bits above the word length are 0
- valid  out  1  one-cycle pulse; data_out and the error flags are meaningful this cycle
- busy  out  1  high from start detection until the cycle valid rises
- parity_error  out  1  qualified by valid
- framing_error  out  1  qualified by valid; stop bit sampled 0

Behaviour:
- Reset values:
  - All outputs 0 on the edge where reset=1; state returns to IDLE.
  - The line history register is set to 1.
  - Reset mid-frame abandons the frame; valid is not raised.
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
- Sample tick:
  - OSR=1: every cycle.
  - OSR>1: tick counter cnt wraps at OSR-1; a sample is taken when cnt==OSR-1.
- IDLE:
  - A falling edge is required: previous sample 1, current sample 0. A line held low never re-triggers.
  - On the edge, latch PEN/EPS/SP/WLS into frame registers. Config changes mid-frame are ignored.
  - Set busy=1, clear the shift register and bit index.
  - OSR=1: the edge sample counts as the start bit; go straight to DATA_BITS.
  - OSR>1: go to START_BIT with cnt=0.
- START_BIT (OSR>1 only): at cnt==OSR/2-1, re-check rx.
  - rx=0: reset cnt, go to DATA_BITS.
  - rx=1: false start; return to IDLE with busy=0.
- DATA_BITS:
  - On each sample: shift_reg[bit_idx] <= rx, then increment bit_idx.
  - After bit WLS+4 (bit 4 of a 5-bit word through bit 7 of an 8-bit word): go to PARITY_BIT if PEN, else STOP_BIT.
- PARITY_BIT: compute expected parity over the received bits only.
  - SP=0, EPS=1: expected = ^data.
  - SP=0, EPS=0: expected = ~^data.
  - SP=1: expected = ~EPS.
  - Latch the mismatch, then go to STOP_BIT.
- STOP_BIT: on the sample:
  - framing_error = ~rx.
  - data_out <= shift_reg; valid <= 1; busy <= 0.
  - Return to IDLE.
- Latency (OSR=1): with the start bit sampled at edge E0 and an 8-bit word plus parity, the stop bit is sampled at E10. valid, data_out and the flags are high in the cycle after E10.
- valid and the error flags are pulses that deassert the next cycle. data_out holds until the next valid.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE sees stop=1 then start=0, which is a valid falling edge.

Optional Feature:
- Macro: RX_BREAK_DETECT_EN.
- Defined:
  - Adds output break_detect (1 bit), reset 0.
  - Condition: a frame whose data bits, parity bit (if enabled) and stop bit are all 0.
  - Response: break_detect pulses with valid; framing_error is still set; data_out=0.
- Undefined: the port is absent; such a frame is reported only as framing_error with data_out=0.

Decomposition:
- Shared package `uart_pkg`: state encodings shared with the transmitter (IDLE 3'b010, START_BIT 3'b011, DATA_BITS 3'b100, PARITY_BIT 3'b101, STOP_BIT 3'b110, RESET 3'b000), the WLS codes, and a parity-expectation function (data, wls, EPS, SP).
- Sub-module `rx_sample_tick`: the input synchronizer, falling-edge detect and OSR tick counter. The FSM stays in the top module.

Test Plan:
- Loopback with the transmitter, OSR=1, WLS=11, PEN=1, EPS=1, SP=0, data 0xA5 → line 0,1,0,1,0,0,1,0,1,0,1. Required: valid one cycle after the stop sample, data_out=0xA5, parity_error=0, framing_error=0.
- WLS=00, PEN=0, data 0x1F then 0x0A sent back-to-back → two valid pulses exactly 7 cycles apart, data_out=0x1F then 0x0A, upper bits 0.
- PEN=1, EPS=0, SP=0, word 0x03 with parity bit forced to 0 (expected 1) → valid with parity_error=1. Then SP=1, EPS=1, bit 0 → no error.
- Stop bit forced to 0 on 0x55 → framing_error=1, data_out=0x55. Then rx held low for 20 cycles → no further valid until rx returns high and falls again.
- Break: rx low for 30 cycles → framing_error=1, data_out=0. With RX_BREAK_DETECT_EN defined, break_detect=1 in the same cycle.
- Reset asserted at bit 4 of a frame → busy=0 and valid=0 next cycle. Remaining bits ignored until a new falling edge. OSR=16 with a 3-cycle low glitch → START_BIT aborts and no valid is raised.
